// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access-legality helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = |addr_lo;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores only have B/H/W encodings; loads additionally allow BU/HU.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic bad;
    if (we) bad = (funct3 > F3_W);
    else    bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word and
// merges sub-word store data into a previously read word (little-endian).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic [31:0] o_new_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_rdata = i_word;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h000000, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0000, w_half};
      default: o_rdata = i_word;
    endcase
  end

  // Untouched lanes keep the value read back from memory.
  always_comb begin
    o_new_word = i_old_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0: o_new_word[7:0]   = i_wdata[7:0];
          2'd1: o_new_word[15:8]  = i_wdata[7:0];
          2'd2: o_new_word[23:16] = i_wdata[7:0];
          2'd3: o_new_word[31:24] = i_wdata[7:0];
          default: o_new_word = i_old_word;
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) o_new_word[31:16] = i_wdata[15:0];
        else              o_new_word[15:0]  = i_wdata[15:0];
      end
      default: o_new_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from execute, drives the
// word-wide DataMem port and returns a single-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addrOut,
  output logic [31:0]       dataW,
  input  logic [31:0]       dataR,
  output logic              memR,
  output logic              memW
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_req_err = is_illegal(req_we, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .i_word     (r_rbuf),
    .i_old_word (r_rbuf),
    .i_wdata    (r_wdata),
    .i_addr_lo  (r_addr[1:0]),
    .i_funct3   (r_funct3),
    .o_rdata    (w_load),
    .o_new_word (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                         w_next = S_RESP;
          else if (req_we && req_funct3 == F3_W) w_next = S_WR;
          else                                   w_next = S_RD;
        end
      end
      S_RD:    w_next = S_WAIT;
      S_WAIT:  w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so execute may move on immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_err    <= w_req_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_rbuf <= 32'h0;
    else if (r_state == S_WAIT) r_rbuf <= dataR;
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    memR       = (r_state == S_RD);
    memW       = (r_state == S_WR);
    resp_valid = (r_state == S_RESP);
    resp_err   = (r_state == S_RESP) && r_err;
    resp_rdata = 32'h0;
    addrOut    = '0;
    dataW      = 32'h0;
    if (r_state == S_RD || r_state == S_WAIT || r_state == S_WR)
      addrOut = {r_addr[ADDR_W-1:2], 2'b00};
    if (r_state == S_WR)
      dataW = w_merged;
    if (r_state == S_RESP && !r_err && !r_we)
      resp_rdata = w_load;
  end

endmodule
